// File: rtl/uart_tx_ctrl.sv
// Sends a latched 16-bit result word to the UART byte engine as two bytes.
// Latency: trigger at edge 0 gives the first tx_start during cycle 1+max(D,1).
// Backpressure: holds in SEND while tx_busy is high; each byte uses a start/busy handshake.
module uart_tx_ctrl #(
    parameter int WAIT_FOR_REGISTER_DELAY = 100,
    parameter bit MSB_FIRST               = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] data_in,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  LED
);

    // A zero delay is treated as one so REGISTER always lasts at least a cycle.
    localparam int DLY = (WAIT_FOR_REGISTER_DELAY < 1) ? 1 : WAIT_FOR_REGISTER_DELAY;
    localparam int CW  = (DLY < 2) ? 1 : $clog2(DLY);
    localparam logic [CW-1:0] CNT_LAST = CW'(DLY - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        REGISTER = 4'd1,
        SEND_B0  = 4'd2,
        ACK_B0   = 4'd3,
        WAIT_B0  = 4'd4,
        SEND_B1  = 4'd5,
        ACK_B1   = 4'd6,
        WAIT_B1  = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     word_q, word_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte0, byte1;

    // First byte on the wire is the low half unless MSB_FIRST is set.
    assign byte0 = MSB_FIRST ? word_q[15:8] : word_q[7:0];
    assign byte1 = MSB_FIRST ? word_q[7:0]  : word_q[15:8];

    // State, word and settle-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic plus the single-cycle tx_start and done pulses.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        tx_start = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                // The word is only captured here, so triggers mid-transfer are ignored.
                if (trigger) begin
                    word_d  = data_in;
                    cnt_d   = '0;
                    state_d = REGISTER;
                end
            end
            REGISTER: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SEND_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND_B0: begin
                // Only start once the previous frame has finished shifting.
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = ACK_B0;
                end
            end
            ACK_B0: begin
                if (tx_busy) begin
                    state_d = WAIT_B0;
                end
            end
            WAIT_B0: begin
                if (!tx_busy) begin
                    state_d = SEND_B1;
                end
            end
            SEND_B1: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = ACK_B1;
                end
            end
            ACK_B1: begin
                if (tx_busy) begin
                    state_d = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (!tx_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Byte presented to the transmitter; held constant from SEND through WAIT.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            SEND_B0, ACK_B0, WAIT_B0: tx_data = byte0;
            SEND_B1, ACK_B1, WAIT_B1: tx_data = byte1;
            default:                  tx_data = 8'h00;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign LED  = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl over three parameter sets sharing clock and reset.
// Instance 0: D=4 LSB first; instance 1: D=4 MSB first; instance 2: D=0 LSB first.
// A simple TX engine model raises busy the cycle after tx_start and holds it 10 cycles.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig    [3];
    logic [15:0] din     [3];
    logic        txb     [3];
    logic        hold_hi [3];
    logic        txs     [3];
    logic [7:0]  txd     [3];
    logic        bsy     [3];
    logic        dn      [3];
    logic [3:0]  led     [3];

    int          mdl_cnt [3];
    int          n_start [3];
    int          n_done  [3];
    int          n_reg   [3];
    int          n_busy  [3];
    int          n_dbl   [3];
    bit          prev_s  [3];
    logic [7:0]  blog    [3][32];

    int vecs = 0;
    int errs = 0;

    int b_s, b_d, b_r, b_b;

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < 3; k++) begin : g_dut
            uart_tx_ctrl #(
                .WAIT_FOR_REGISTER_DELAY((k == 2) ? 0 : 4),
                .MSB_FIRST              (k == 1)
            ) u_dut (
                .clk     (clk),
                .reset   (reset),
                .trigger (trig[k]),
                .data_in (din[k]),
                .tx_busy (txb[k]),
                .tx_start(txs[k]),
                .tx_data (txd[k]),
                .busy    (bsy[k]),
                .done    (dn[k]),
                .LED     (led[k])
            );
            assign txb[k] = (mdl_cnt[k] != 0) | hold_hi[k];
        end
    endgenerate

    // UART byte engine model: busy for 10 cycles starting the cycle after tx_start.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) mdl_cnt[k] <= 0;
            else if (txs[k] === 1'b1) mdl_cnt[k] <= 10;
            else if (mdl_cnt[k] != 0) mdl_cnt[k] <= mdl_cnt[k] - 1;
        end
    end

    // Mid-cycle observer: logs sent bytes and counts pulses and state residency.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset === 1'b0) begin
                if (txs[k] === 1'b1) begin
                    if (n_start[k] < 32) blog[k][n_start[k]] = txd[k];
                    if (prev_s[k]) n_dbl[k]++;
                    n_start[k]++;
                end
                prev_s[k] = (txs[k] === 1'b1);
                if (dn[k] === 1'b1) n_done[k]++;
                if (led[k] === 4'd1) n_reg[k]++;
                if (bsy[k] === 1'b1) n_busy[k]++;
            end else begin
                prev_s[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pulse(input int k, input logic [15:0] d);
        @(negedge clk);
        din[k]  = d;
        trig[k] = 1'b1;
        @(negedge clk);
        trig[k] = 1'b0;
    endtask

    task automatic wait_state(input int k, input logic [3:0] s, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (led[k] === s) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_idle(input int k, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (bsy[k] === 1'b0) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_done(input int k, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (dn[k] === 1'b1) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic snap(input int k);
        b_s = n_start[k];
        b_d = n_done[k];
        b_r = n_reg[k];
        b_b = n_busy[k];
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            trig[k]    = 1'b0;
            din[k]     = 16'h0000;
            hold_hi[k] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state on every instance
        for (int k = 0; k < 3; k++) begin
            chk("rst led",      32'(led[k]), 32'd0);
            chk("rst busy",     32'(bsy[k]), 32'd0);
            chk("rst tx_start", 32'(txs[k]), 32'd0);
            chk("rst done",     32'(dn[k]),  32'd0);
            chk("rst tx_data",  32'(txd[k]), 32'd0);
        end
        reset = 1'b0;

        // 1: D=4, LSB first, 16'hA55A
        snap(0);
        pulse(0, 16'hA55A);
        wait_idle(0, "t1 idle");
        chk("t1 reg cycles",  32'(n_reg[0]  - b_r), 32'd4);
        chk("t1 busy cycles", 32'(n_busy[0] - b_b), 32'd29);
        chk("t1 starts",      32'(n_start[0] - b_s), 32'd2);
        chk("t1 done",        32'(n_done[0] - b_d), 32'd1);
        chk("t1 byte0",       32'(blog[0][b_s]),     32'h5A);
        chk("t1 byte1",       32'(blog[0][b_s + 1]), 32'hA5);

        // 2: MSB first, 16'h1234
        snap(1);
        pulse(1, 16'h1234);
        wait_idle(1, "t2 idle");
        chk("t2 starts", 32'(n_start[1] - b_s), 32'd2);
        chk("t2 done",   32'(n_done[1] - b_d),  32'd1);
        chk("t2 byte0",  32'(blog[1][b_s]),     32'h12);
        chk("t2 byte1",  32'(blog[1][b_s + 1]), 32'h34);

        // 3: tx_busy held high for 7 cycles from SEND_B0 entry
        snap(0);
        hold_hi[0] = 1'b1;
        pulse(0, 16'hBEEF);
        wait_state(0, 4'd2, "t3 reach send");
        repeat (6) @(negedge clk);
        chk("t3 still send",   32'(led[0]), 32'd2);
        chk("t3 no start yet", 32'(n_start[0] - b_s), 32'd0);
        @(posedge clk);
        #1 hold_hi[0] = 1'b0;
        wait_idle(0, "t3 idle");
        chk("t3 starts", 32'(n_start[0] - b_s), 32'd2);
        chk("t3 byte0",  32'(blog[0][b_s]),     32'hEF);
        chk("t3 byte1",  32'(blog[0][b_s + 1]), 32'hBE);
        chk("t3 done",   32'(n_done[0] - b_d),  32'd1);

        // 4: trigger during WAIT_B0 is ignored
        snap(0);
        pulse(0, 16'h0001);
        wait_state(0, 4'd4, "t4 reach wait_b0");
        din[0]  = 16'hFFFF;
        trig[0] = 1'b1;
        @(negedge clk);
        trig[0] = 1'b0;
        wait_idle(0, "t4 idle");
        chk("t4 byte0",  32'(blog[0][b_s]),     32'h01);
        chk("t4 byte1",  32'(blog[0][b_s + 1]), 32'h00);
        chk("t4 starts", 32'(n_start[0] - b_s), 32'd2);
        chk("t4 done",   32'(n_done[0] - b_d),  32'd1);
        repeat (20) @(negedge clk);
        chk("t4 stays idle",   32'(led[0]), 32'd0);
        chk("t4 no 2nd xfer",  32'(n_start[0] - b_s), 32'd2);

        // 5: reset during ACK_B1 aborts, then a normal transfer
        snap(0);
        pulse(0, 16'h7E81);
        wait_state(0, 4'd6, "t5 reach ack_b1");
        reset = 1'b1;
        @(negedge clk);
        chk("t5 led",      32'(led[0]), 32'd0);
        chk("t5 busy",     32'(bsy[0]), 32'd0);
        chk("t5 done",     32'(dn[0]),  32'd0);
        chk("t5 tx_start", 32'(txs[0]), 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5 no done pulse",  32'(n_done[0] - b_d),  32'd0);
        chk("t5 aborted starts", 32'(n_start[0] - b_s), 32'd2);
        snap(0);
        pulse(0, 16'h00C3);
        wait_idle(0, "t5 idle");
        chk("t5 byte0",  32'(blog[0][b_s]),     32'hC3);
        chk("t5 byte1",  32'(blog[0][b_s + 1]), 32'h00);
        chk("t5 done2",  32'(n_done[0] - b_d),  32'd1);

        // 6: D=0, second trigger in the cycle after done
        snap(2);
        pulse(2, 16'h1122);
        wait_done(2, "t6 first done");
        pulse(2, 16'h3344);
        wait_idle(2, "t6 idle");
        chk("t6 reg cycles", 32'(n_reg[2] - b_r),   32'd2);
        chk("t6 starts",     32'(n_start[2] - b_s), 32'd4);
        chk("t6 dones",      32'(n_done[2] - b_d),  32'd2);
        chk("t6 byte0",      32'(blog[2][b_s]),     32'h22);
        chk("t6 byte1",      32'(blog[2][b_s + 1]), 32'h11);
        chk("t6 byte2",      32'(blog[2][b_s + 2]), 32'h44);
        chk("t6 byte3",      32'(blog[2][b_s + 3]), 32'h33);

        // tx_start never high on two consecutive cycles
        for (int k = 0; k < 3; k++) begin
            chk("back-to-back start", 32'(n_dbl[k]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
